// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate vector sequencer.
package gate_seq_pkg;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned VEC_W       = 2;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StDone
  } seq_state_e;

  // Vector index maps straight onto the gate inputs, A in the MSB.
  function automatic logic [1:0] vec_to_ab(input logic [VEC_W-1:0] vec);
    return {vec[1], vec[0]};
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-vector hold timer: expire is high on the last cycle of each dwell while enabled.
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned TimerW = $clog2(DWELL_CYCLES) + 1;
  localparam logic [TimerW-1:0] LastCount = TimerW'(DWELL_CYCLES - 1);

  logic [TimerW-1:0] count_q;

  assign expire = en && (count_q == LastCount);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= expire ? '0 : count_q + TimerW'(1);
    end
  end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Steps a 2-input gate through all four input vectors, captures F per vector and
// checks it against an expected truth table. Optional abort input: GATE_SEQ_ABORT_EN.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_VECTORS-1:0] expected,
  output logic                   gate_a,
  output logic                   gate_b,
  input  logic                   gate_f,
  output logic                   busy,
  output logic [VEC_W-1:0]       vec_idx,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] truth_table,
  output logic [NUM_VECTORS-1:0] mismatch_mask
`ifdef GATE_SEQ_ABORT_EN
  ,
  input  logic                   abort
`endif
);

  seq_state_e             state_q;
  logic [NUM_VECTORS-1:0] exp_q;
  logic [NUM_VECTORS-1:0] tt_next;
  logic                   abort_req;
  logic                   timer_clear;
  logic                   timer_en;
  logic                   timer_expire;

`ifdef GATE_SEQ_ABORT_EN
  assign abort_req = abort && (state_q == StApply);
`else
  assign abort_req = 1'b0;
`endif

  assign timer_clear = (state_q == StIdle) && start;
  assign timer_en    = (state_q == StApply) && !abort_req;

  dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Truth table including the bit captured at this edge, so pass/mask are valid with done.
  always_comb begin
    tt_next          = truth_table;
    tt_next[vec_idx] = gate_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      exp_q         <= '0;
      gate_a        <= 1'b0;
      gate_b        <= 1'b0;
      busy          <= 1'b0;
      vec_idx       <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      truth_table   <= '0;
      mismatch_mask <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          gate_a <= 1'b0;
          gate_b <= 1'b0;
          busy   <= 1'b0;
          if (start) begin
            exp_q            <= expected;
            truth_table      <= '0;
            pass             <= 1'b0;
            mismatch_mask    <= '0;
            vec_idx          <= '0;
            {gate_a, gate_b} <= vec_to_ab('0);
            busy             <= 1'b1;
            state_q          <= StApply;
          end
        end
        StApply: begin
          if (abort_req) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
            pass    <= 1'b0;
          end else if (timer_expire) begin
            truth_table <= tt_next;
            if (vec_idx == VEC_W'(NUM_VECTORS - 1)) begin
              state_q       <= StDone;
              done          <= 1'b1;
              busy          <= 1'b0;
              gate_a        <= 1'b0;
              gate_b        <= 1'b0;
              pass          <= (tt_next == exp_q);
              mismatch_mask <= tt_next ^ exp_q;
            end else begin
              vec_idx          <= vec_idx + VEC_W'(1);
              {gate_a, gate_b} <= vec_to_ab(vec_idx + VEC_W'(1));
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboard bench for gate_vector_sequencer with a randomly chosen gate function.
module tb_gate_vector_sequencer;

  localparam int unsigned D      = 4;
  localparam int          RunLen = 4 * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] expected = 4'b0000;
  logic       gate_a, gate_b, gate_f;
  logic       busy, done, pass;
  logic [1:0] vec_idx;
  logic [3:0] truth_table, mismatch_mask;
  logic [3:0] gate_fn = 4'b1000;
`ifdef GATE_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  // Gate under test: F is the gate_fn bit selected by {A,B}.
  assign gate_f = gate_fn[{gate_a, gate_b}];

  gate_vector_sequencer #(
    .DWELL_CYCLES (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .expected      (expected),
    .gate_a        (gate_a),
    .gate_b        (gate_b),
    .gate_f        (gate_f),
    .busy          (busy),
    .vec_idx       (vec_idx),
    .done          (done),
    .pass          (pass),
    .truth_table   (truth_table),
    .mismatch_mask (mismatch_mask)
`ifdef GATE_SEQ_ABORT_EN
    ,
    .abort         (abort)
`endif
  );

  typedef struct {
    logic [3:0] tt;
    logic [3:0] mm;
    logic       pass;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         run_active = 1'b0;
  int         run_accept = 0;
  logic [3:0] hold_tt = 4'b0000;
  logic [3:0] hold_mm = 4'b0000;
  logic       hold_pass = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard on done and tracks the expected vector schedule.
  always @(negedge clk) begin
    int   k;
    exp_t e;
    if (!rst_n) begin
      check("reset_outputs",
            32'({gate_a, gate_b, busy, vec_idx, done, pass, truth_table, mismatch_mask}), 0);
    end else begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          e = sb.pop_front();
          check("done_latency", 32'(cyc), 32'(e.due));
          check("truth_table", 32'(truth_table), 32'(e.tt));
          check("pass", 32'(pass), 32'(e.pass));
          check("mismatch_mask", 32'(mismatch_mask), 32'(e.mm));
          hold_tt   = e.tt;
          hold_mm   = e.mm;
          hold_pass = e.pass;
        end
      end
      if (run_active) begin
        k = cyc - run_accept;
        if (k < RunLen) begin
          check("busy_in_run", 32'(busy), 1);
          check("gate_ab", 32'({gate_a, gate_b}), 32'(k / int'(D)));
          check("vec_idx", 32'(vec_idx), 32'(k / int'(D)));
          check("early_done", 32'(done), 0);
        end else begin
          check("done_pulse", 32'(done), 1);
          check("busy_at_done", 32'(busy), 0);
          check("gate_ab_at_done", 32'({gate_a, gate_b}), 0);
          run_active = 1'b0;
        end
      end else if (!done) begin
        check("idle_busy", 32'(busy), 0);
        check("idle_gate_ab", 32'({gate_a, gate_b}), 0);
        check("idle_hold_tt", 32'(truth_table), 32'(hold_tt));
        check("idle_hold_pass", 32'(pass), 32'(hold_pass));
        check("idle_hold_mm", 32'(mismatch_mask), 32'(hold_mm));
      end
    end
  end

  // Called just after the edge that accepts start; records the spec-level expectation.
  task automatic accepted(input logic [3:0] fn, input logic [3:0] ex);
    exp_t e;
    e.tt   = fn;
    e.mm   = fn ^ ex;
    e.pass = (fn == ex);
    e.due  = cyc + RunLen;
    sb.push_back(e);
    run_accept = cyc;
    run_active = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (run_active && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (run_active) begin
      check("run_timeout", 32'(run_active), 0);
      run_active = 1'b0;
    end
  endtask

  task automatic begin_run(input logic [3:0] fn, input logic [3:0] ex);
    gate_fn  = fn;
    expected = ex;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    accepted(fn, ex);
  endtask

  task automatic run(input logic [3:0] fn, input logic [3:0] ex);
    begin_run(fn, ex);
    wait_idle();
  endtask

  initial begin
    logic [3:0] fn;
    logic [3:0] ex;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // AND gate against its own table, then against an OR table.
    run(4'b1000, 4'b1000);
    run(4'b1000, 4'b1110);

    // Start pulse mid-run is ignored; a following run is normal.
    begin_run(4'b1000, 4'b1000);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    run(4'b1000, 4'b1000);

    // Reset mid-run: outputs clear at once, no done pulse.
    begin_run(4'b1000, 4'b1000);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    run_active = 1'b0;
    hold_tt    = 4'b0000;
    hold_mm    = 4'b0000;
    hold_pass  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run(4'b1000, 4'b1000);

    // Start held high: second run accepted after one idle cycle.
    gate_fn  = 4'b0110;
    expected = 4'b0110;
    start    = 1'b1;
    @(posedge clk);
    #1;
    accepted(4'b0110, 4'b0110);
    repeat (RunLen + 2) @(posedge clk);
    #1;
    start = 1'b0;
    accepted(4'b0110, 4'b0110);
    wait_idle();

    // Random gate functions and expected tables.
    for (int i = 0; i < 10; i++) begin
      fn = 4'($urandom);
      ex = ($urandom_range(0, 1) == 0) ? fn : 4'($urandom);
      run(fn, ex);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

`ifdef GATE_SEQ_ABORT_EN
    // Abort after vector 0 was captured: back to idle, no done, partial table kept.
    begin_run(4'b1000, 4'b1000);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    void'(sb.pop_back());
    run_active = 1'b0;
    hold_tt    = 4'b0000;
    hold_mm    = 4'b0000;
    hold_pass  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    run(4'b1000, 4'b1000);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
- Controller that exercises a 2-input combinational gate (the Testgate datapath).
- Steps the gate inputs through all four {A,B} combinations, holding each for a programmable dwell time, and samples output F at the end of each dwell.
- Assembles the captured 4-entry truth table and compares it against an expected table.
- Replaces the free-running delay-based stimulus with a clocked, self-checking sequence usable in synthesizable self-test.

Parameters:
- DWELL_CYCLES, 10: clock cycles each input vector is held; legal values are 1 and above.
- NUM_VECTORS, 4: number of input combinations; fixed at 4 for a 2-input gate.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a run; sampled on each rising edge; used only in IDLE.
- expected  input  4  expected truth table; bit i corresponds to {A,B}=i (A is the MSB); captured when start is accepted.
- gate_a  output  1  drive to gate input A.
- gate_b  output  1  drive to gate input B.
- gate_f  input  1  gate output F.
- busy  output  1  high while in APPLY.
- vec_idx  output  2  index of the current vector.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  truth_table equals expected; valid from done onward, held until the next accepted start.
- truth_table  output  4  captured F values; bit i is the F sampled for vector i.
- mismatch_mask  output  4  truth_table XOR captured expected; valid and held with pass.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. gate_a, gate_b, busy, done, pass, vec_idx, truth_table, mismatch_mask and the dwell timer all clear to 0.
- IDLE: gate_a=gate_b=0.
  - start=1 at an edge → capture expected into exp_q; clear truth_table, pass and mismatch_mask; set vec_idx=0 and timer=0; go to APPLY.
  - pass, truth_table and mismatch_mask hold their values while idle.
- APPLY: busy=1; {gate_a,gate_b}=vec_idx (registered outputs). The timer increments every cycle.
  - Edge with timer==DWELL_CYCLES-1: truth_table[vec_idx]<=gate_f.
  - At that same edge, if vec_idx==3, go to DONE.
  - Otherwise vec_idx<=vec_idx+1 and timer<=0.
- Timing: each vector is held exactly DWELL_CYCLES cycles. busy stays high for 4*DWELL_CYCLES cycles. F is sampled on the last edge of each dwell.
- DONE (single cycle):
  - done=1, busy=0, gate_a=gate_b=0.
  - pass=(truth_table==exp_q); mismatch_mask=truth_table^exp_q.
  - Next state is IDLE.
- Latency: from the edge accepting start to the done-high cycle is 4*DWELL_CYCLES cycles.
- start in APPLY or DONE is ignored; it is not queued.
- start held high continuously: a new run is accepted on the first IDLE edge after DONE, giving back-to-back runs with one IDLE cycle between them.
- vec_idx does not wrap inside a run; it resets to 0 only on accepting start.
- DWELL_CYCLES=1: the vector changes every cycle and every APPLY edge samples F.
- Timer width is $clog2(DWELL_CYCLES)+1 bits; no overflow is possible.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no done pulse.

Optional Feature:
Macro: GATE_SEQ_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 at an APPLY edge → next state is IDLE, busy=0, gate_a=gate_b=0, pass=0, no done pulse.
  - truth_table keeps the bits already captured.
  - abort takes priority over the sample/advance at the same edge, so F is not captured at that edge.
  - abort in IDLE or DONE has no effect.
- Undefined: the port does not exist and a run always completes.

Decomposition:
- Package gate_seq_pkg holds:
  - the state typedef enum {IDLE, APPLY, DONE};
  - localparam NUM_VECTORS=4 and VEC_W=2;
  - a function vec_to_ab(vec) returning {A,B}.
- Sub-module dwell_timer (parameter DWELL_CYCLES; inputs clk, rst_n, clear, en; output expire) generates the per-vector hold strobe.

Test Plan (DWELL_CYCLES=4, gate = AND):
- expected=4'b1000, pulse start → done exactly 16 cycles after start is accepted; truth_table=4'b1000, pass=1, mismatch_mask=4'b0000.
- expected=4'b1110 (OR pattern) → truth_table=4'b1000, pass=0, mismatch_mask=4'b0110.
- Monitor gate_a/gate_b during a run → 00, 01, 10, 11, each held exactly 4 cycles; busy high for 16 cycles; 00 afterwards.
- start pulsed at cycle 5 of a run → ignored: a single done pulse, timing unchanged; a later start from IDLE runs normally.
- rst_n low at cycle 9 of a run → all outputs 0 immediately; no done pulse; a new start afterwards runs fully and gives pass=1.
- GATE_SEQ_ABORT_EN defined: abort at cycle 6 → IDLE next edge, busy=0, no done, pass=0, truth_table=4'b0000 (vector 0 captured 0).
